// File: rtl/seg_scan_driver.sv
// Multiplexed 7-segment scan driver: double-buffered BCD digits, active-low outputs,
// one dead-time clock per slot. Define LEADING_ZERO_BLANK_EN to blank leading zeros.
module seg_scan_driver #(
  parameter int NDIG     = 4,
  parameter int SCAN_DIV = 50000
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  input  logic                ld,
  input  logic [4*NDIG-1:0]   bcd,
  input  logic [NDIG-1:0]     dp,
  output logic [6:0]          seg,
  output logic                dp_n,
  output logic [NDIG-1:0]     an,
  output logic                frame
);

  localparam int DW = $clog2(SCAN_DIV);
  localparam int IW = $clog2(NDIG);
  localparam logic [DW-1:0] DIV_LAST = DW'(SCAN_DIV - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(NDIG - 1);

  logic [DW-1:0]     div_q;
  logic [IW-1:0]     idx_q;
  logic [4*NDIG-1:0] shadow_bcd, act_bcd;
  logic [NDIG-1:0]   shadow_dp, act_dp;
  logic              slot_end, frame_end;

  assign slot_end  = en && (div_q == DIV_LAST);
  assign frame_end = slot_end && (idx_q == IDX_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_q <= '0;
      idx_q <= '0;
    end else if (en) begin
      div_q <= slot_end ? '0 : div_q + DW'(1);
      if (slot_end)
        idx_q <= (idx_q == IDX_LAST) ? '0 : idx_q + IW'(1);
    end
  end

  // A load on the boundary cycle bypasses the shadow so it shows in the very next frame.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shadow_bcd <= '0;
      shadow_dp  <= '0;
      act_bcd    <= '0;
      act_dp     <= '0;
    end else begin
      if (ld) begin
        shadow_bcd <= bcd;
        shadow_dp  <= dp;
      end
      if (frame_end) begin
        act_bcd <= ld ? bcd : shadow_bcd;
        act_dp  <= ld ? dp  : shadow_dp;
      end
    end
  end

  function automatic logic [6:0] seg_decode(input logic [3:0] d);
    case (d)
      4'd0:    seg_decode = 7'b1000000;
      4'd1:    seg_decode = 7'b1111001;
      4'd2:    seg_decode = 7'b0100100;
      4'd3:    seg_decode = 7'b0110000;
      4'd4:    seg_decode = 7'b0011001;
      4'd5:    seg_decode = 7'b0010010;
      4'd6:    seg_decode = 7'b0000010;
      4'd7:    seg_decode = 7'b1111000;
      4'd8:    seg_decode = 7'b0000000;
      4'd9:    seg_decode = 7'b0010000;
      default: seg_decode = 7'b1111111;
    endcase
  endfunction

  logic [3:0]      cur_digit;
  logic            cur_dp;
  logic            cur_blank;
  logic [NDIG-1:0] sel;
  logic [NDIG-1:0] upper_zero;

  always_comb begin
    cur_digit  = '0;
    cur_dp     = 1'b0;
    cur_blank  = 1'b0;
    sel        = '0;
    upper_zero = '0;
`ifdef LEADING_ZERO_BLANK_EN
    // upper_zero[k]: digits k..NDIG-1 are all zero
    upper_zero[NDIG-1] = (act_bcd[4*(NDIG-1) +: 4] == 4'd0);
    for (int k = NDIG - 2; k >= 0; k--)
      upper_zero[k] = upper_zero[k+1] && (act_bcd[4*k +: 4] == 4'd0);
`endif
    for (int k = 0; k < NDIG; k++) begin
      if (idx_q == IW'(k)) begin
        sel[k]    = 1'b1;
        cur_digit = act_bcd[4*k +: 4];
        cur_dp    = act_dp[k];
        cur_blank = (k > 0) && upper_zero[k];
      end
    end
  end

  logic [6:0]      seg_d;
  logic            dp_n_d;
  logic [NDIG-1:0] an_d;
  logic            frame_d;

  always_comb begin
    seg_d   = '1;
    dp_n_d  = 1'b1;
    an_d    = '1;
    frame_d = 1'b0;
    if (en) begin
      if (div_q == '0) begin
        frame_d = (idx_q == '0);
      end else begin
        an_d   = ~sel;
        seg_d  = cur_blank ? 7'b1111111 : seg_decode(cur_digit);
        dp_n_d = ~cur_dp;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      seg   <= '1;
      dp_n  <= 1'b1;
      an    <= '1;
      frame <= 1'b0;
    end else begin
      seg   <= seg_d;
      dp_n  <= dp_n_d;
      an    <= an_d;
      frame <= frame_d;
    end
  end

endmodule

// File: tb/tb_seg_scan_driver.sv
// Bench for seg_scan_driver (NDIG=4, SCAN_DIV=4): frame-position reference model,
// per-cycle compare, directed literal checks and randomized load/enable traffic.
module tb_seg_scan_driver;
  localparam int NDIG      = 4;
  localparam int SCAN_DIV  = 4;
  localparam int FRAME_LEN = NDIG * SCAN_DIV;

  logic              clk = 1'b0;
  logic              rst, en, ld;
  logic [4*NDIG-1:0] bcd;
  logic [NDIG-1:0]   dp;
  logic [6:0]        seg;
  logic              dp_n;
  logic [NDIG-1:0]   an;
  logic              frame;

  seg_scan_driver #(.NDIG(NDIG), .SCAN_DIV(SCAN_DIV)) dut (
    .clk(clk), .rst(rst), .en(en), .ld(ld), .bcd(bcd), .dp(dp),
    .seg(seg), .dp_n(dp_n), .an(an), .frame(frame)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got === want) n_pass++;
    else $display("FAIL %s: got %0h want %0h at %0t", name, got, want, $time);
  endtask

  logic [6:0] seg_tab [16] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                               7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                               7'b0000000, 7'b0010000, 7'h7f, 7'h7f,
                               7'h7f, 7'h7f, 7'h7f, 7'h7f};

  // Reference model: position within the frame (0..FRAME_LEN-1) plus shadow/active copies
  int                pos;
  int                m_d, m_digit;
  bit                m_blank;
  logic [4*NDIG-1:0] m_sh_bcd, m_act_bcd;
  logic [NDIG-1:0]   m_sh_dp, m_act_dp;
  logic [6:0]        e_seg;
  logic              e_dpn;
  logic [NDIG-1:0]   e_an;
  logic              e_frame;
  bit                cmp_on = 1'b0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      pos = 0;
      m_sh_bcd = '0; m_act_bcd = '0; m_sh_dp = '0; m_act_dp = '0;
      e_seg = '1; e_dpn = 1'b1; e_an = '1; e_frame = 1'b0;
    end else begin
      e_seg = '1; e_dpn = 1'b1; e_an = '1; e_frame = 1'b0;
      if (en) begin
        m_d = pos / SCAN_DIV;
        if (pos % SCAN_DIV == 0) begin
          e_frame = (pos == 0);
        end else begin
          m_digit = int'((m_act_bcd >> (4 * m_d)) & 16'hF);
          m_blank = 1'b0;
`ifdef LEADING_ZERO_BLANK_EN
          if (m_d > 0 && (m_act_bcd >> (4 * m_d)) == 0) m_blank = 1'b1;
`endif
          e_an  = ~(NDIG'(1) << m_d);
          e_seg = m_blank ? 7'h7f : seg_tab[m_digit];
          e_dpn = ~m_act_dp[m_d];
        end
      end
      if (ld) begin
        m_sh_bcd = bcd;
        m_sh_dp  = dp;
      end
      if (en && pos == FRAME_LEN - 1) begin
        m_act_bcd = m_sh_bcd;
        m_act_dp  = m_sh_dp;
      end
      if (en) pos = (pos + 1) % FRAME_LEN;
    end
  end

  always @(negedge clk) begin
    if (cmp_on) begin
      chk("seg", 32'(seg), 32'(e_seg));
      chk("an", 32'(an), 32'(e_an));
      chk("dp_n", 32'(dp_n), 32'(e_dpn));
      chk("frame", 32'(frame), 32'(e_frame));
    end
  end

  task automatic wait_frame();
    bit found = 1'b0;
    for (int i = 0; i < 4 * FRAME_LEN && !found; i++) begin
      @(negedge clk);
      if (frame === 1'b1) found = 1'b1;
    end
    chk("frame_wait", 32'(found), 32'd1);
  endtask

  logic [6:0] lead_seg;

  initial begin
    rst = 1'b1; en = 1'b0; ld = 1'b0; bcd = '0; dp = '0;
    cmp_on = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_an", 32'(an), 32'hf);
    chk("rst_seg", 32'(seg), 32'h7f);
    chk("rst_dpn", 32'(dp_n), 32'd1);

    // Release with a load on the first edge; first frame still shows zeros
    rst = 1'b0; en = 1'b1; ld = 1'b1; bcd = 16'h1234; dp = 4'b0000;
    @(negedge clk);                 // edge 1: pos 0
    ld = 1'b0;
    chk("first_frame_pulse", 32'(frame), 32'd1);
    chk("first_dead_an", 32'(an), 32'hf);
    @(negedge clk);                 // edge 2: pos 1
    chk("first_frame_d0", 32'(seg), 32'(7'b1000000));
    chk("first_frame_an0", 32'(an), 32'(4'b1110));
    repeat (16) @(negedge clk);     // edge 18: frame 2, pos 1
    chk("f2_d0_seg", 32'(seg), 32'(7'b0011001));
    chk("f2_d0_an", 32'(an), 32'(4'b1110));
    repeat (12) @(negedge clk);     // edge 30: pos 13
    chk("f2_d3_seg", 32'(seg), 32'(7'b1111001));
    chk("f2_d3_an", 32'(an), 32'(4'b0111));
    @(negedge clk);                 // edge 31
    ld = 1'b1; bcd = 16'h5678;      // sampled on edge 32, the frame boundary
    @(negedge clk);
    ld = 1'b0;
    @(negedge clk);                 // edge 33: pos 0
    chk("bnd_frame", 32'(frame), 32'd1);
    @(negedge clk);                 // edge 34: pos 1 -> digit0 = 8
    chk("bnd_ld_d0", 32'(seg), 32'(7'b0000000));

    // Randomized enable/load traffic
    for (int c = 0; c < 3000; c++) begin
      en = ($urandom_range(0, 9) != 0);
      ld = ($urandom_range(0, 7) == 0);
      for (int k = 0; k < NDIG; k++)
        bcd[4*k +: 4] = ($urandom_range(0, 2) == 0) ? 4'h0 : 4'($urandom_range(0, 15));
      dp = NDIG'($urandom);
      @(negedge clk);
    end
    ld = 1'b0; en = 1'b1;
    @(negedge clk);

    // Disable for 10 cycles
    en = 1'b0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      chk("dis_an", 32'(an), 32'hf);
      chk("dis_frame", 32'(frame), 32'd0);
    end
    en = 1'b1;
    repeat (3) @(negedge clk);

    // Asynchronous reset between edges
    #2 rst = 1'b1;
    #1;
    chk("async_an", 32'(an), 32'hf);
    chk("async_seg", 32'(seg), 32'h7f);
    chk("async_dpn", 32'(dp_n), 32'd1);
    @(negedge clk);
    rst = 1'b0; en = 1'b1;
    @(negedge clk);
    chk("post_rst_frame", 32'(frame), 32'd1);
    @(negedge clk);
    chk("post_rst_seg", 32'(seg), 32'(7'b1000000));
    chk("post_rst_an", 32'(an), 32'(4'b1110));

    // Codes above 9, decimal point and leading zeros
    ld = 1'b1; bcd = 16'h00A7; dp = 4'b0010;
    @(negedge clk);
    ld = 1'b0;
    wait_frame();
    wait_frame();
    @(negedge clk);
    chk("a7_d0_seg", 32'(seg), 32'(7'b1111000));
    chk("a7_d0_dpn", 32'(dp_n), 32'd1);
    repeat (4) @(negedge clk);
    chk("a7_d1_seg", 32'(seg), 32'h7f);
    chk("a7_d1_dpn", 32'(dp_n), 32'd0);
    chk("a7_d1_an", 32'(an), 32'(4'b1101));
`ifdef LEADING_ZERO_BLANK_EN
    lead_seg = 7'h7f;
`else
    lead_seg = 7'b1000000;
`endif
    repeat (4) @(negedge clk);
    chk("a7_d2_seg", 32'(seg), 32'(lead_seg));
    chk("a7_d2_an", 32'(an), 32'(4'b1011));
    repeat (4) @(negedge clk);
    chk("a7_d3_seg", 32'(seg), 32'(lead_seg));
    chk("a7_d3_an", 32'(an), 32'(4'b0111));

    cmp_on = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
